// File: rtl/permutation_round_ctrl.sv
// permutation_round_ctrl: Ascon permutation round sequencer and 320-bit state register.
// Optional macro PERM_BACK_TO_BACK_EN lets a start in DONE launch the next permutation directly.
module permutation_round_ctrl #(
  parameter int ROUNDS_A = 12,
  parameter int ROUNDS_B = 6
) (
  input  logic             clock_i,
  input  logic             resetb_i,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic [4:0][63:0] state_i,
  input  logic [4:0][63:0] round_state_i,
  output logic [4:0][63:0] round_state_o,
  output logic [3:0]       round_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [4:0][63:0] state_o
);
  if (ROUNDS_A < 1 || ROUNDS_A > 12) begin : g_bad_a
    $error("ROUNDS_A must be in 1..12");
  end
  if (ROUNDS_B < 1 || ROUNDS_B > 12) begin : g_bad_b
    $error("ROUNDS_B must be in 1..12");
  end
  localparam logic [3:0] INIT_A = 4'(12 - ROUNDS_A);
  localparam logic [3:0] INIT_B = 4'(12 - ROUNDS_B);
  localparam logic       LAST_A = (ROUNDS_A == 1);
  localparam logic       LAST_B = (ROUNDS_B == 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;
  fsm_t             r_fsm, w_fsm_nxt;
  logic [4:0][63:0] r_state, w_state_nxt;
  logic [3:0]       r_round, w_round_nxt;
  logic             r_last, w_last_nxt;
  logic             w_load;
  logic             w_final;
`ifdef PERM_BACK_TO_BACK_EN
  assign w_load = start_i && (r_fsm == IDLE || r_fsm == DONE);
`else
  assign w_load = start_i && (r_fsm == IDLE);
`endif
  assign w_final       = r_last || (r_round == 4'd11);
  assign round_state_o = r_state;
  assign state_o       = r_state;
  assign round_o       = r_round;
  assign busy_o        = (r_fsm == RUN);
  assign done_o        = (r_fsm == DONE);
  // next-state: load on accepted start, capture the round chain while running, freeze otherwise
  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_state_nxt = r_state;
    w_round_nxt = r_round;
    w_last_nxt  = r_last;
    if (w_load) begin
      w_fsm_nxt   = RUN;
      w_state_nxt = state_i;
      w_round_nxt = mode_i ? INIT_B : INIT_A;
      w_last_nxt  = mode_i ? LAST_B : LAST_A;
    end else if (r_fsm == RUN) begin
      w_state_nxt = round_state_i;
      w_fsm_nxt   = w_final ? DONE : RUN;
      w_round_nxt = w_final ? r_round : r_round + 4'd1;
    end else if (r_fsm == DONE) begin
      w_fsm_nxt = IDLE;
    end
  end
  // state register with asynchronous abort
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_fsm   <= IDLE;
      r_state <= '0;
      r_round <= '0;
      r_last  <= 1'b0;
    end else begin
      r_fsm   <= w_fsm_nxt;
      r_state <= w_state_nxt;
      r_round <= w_round_nxt;
      r_last  <= w_last_nxt;
    end
  end
endmodule

// File: tb/tb_permutation_round_ctrl.sv
// tb_permutation_round_ctrl: scoreboard bench with an Ascon round reference model.
module tb_permutation_round_ctrl;
  typedef logic [4:0][63:0] st_t;
  typedef struct {st_t st; int acc; int n;} exp_t;
  logic clk = 0, rstn = 1, start = 0, mode = 0, full = 0;
  st_t st_in = '0, rs_in, rs_out, st_out;
  logic [3:0] rnd;
  logic busy, done;
  int total = 0, bad = 0, cyc = 0, run_cnt = 0;
  exp_t sb[$];

  permutation_round_ctrl dut (
    .clock_i(clk), .resetb_i(rstn), .start_i(start), .mode_i(mode),
    .state_i(st_in), .round_state_i(rs_in), .round_state_o(rs_out),
    .round_o(rnd), .busy_o(busy), .done_o(done), .state_o(st_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic st_t pc(input st_t s, input int r);
    s[2] ^= 64'(((15 - r) << 4) | r);
    return s;
  endfunction

  function automatic st_t round_f(input st_t s, input int r);
    logic [63:0] t [5];
    s = pc(s, r);
    s[0] ^= s[4]; s[4] ^= s[3]; s[2] ^= s[1];
    for (int i = 0; i < 5; i++) t[i] = ~s[i] & s[(i + 1) % 5];
    for (int i = 0; i < 5; i++) s[i] ^= t[(i + 1) % 5];
    s[1] ^= s[0]; s[0] ^= s[4]; s[3] ^= s[2]; s[2] = ~s[2];
    s[0] ^= ror(s[0], 19) ^ ror(s[0], 28);
    s[1] ^= ror(s[1], 61) ^ ror(s[1], 39);
    s[2] ^= ror(s[2], 1)  ^ ror(s[2], 6);
    s[3] ^= ror(s[3], 10) ^ ror(s[3], 17);
    s[4] ^= ror(s[4], 7)  ^ ror(s[4], 41);
    return s;
  endfunction

  function automatic st_t perm(input st_t s, input int n, input logic f);
    for (int r = 12 - n; r < 12; r++) s = f ? round_f(s, r) : pc(s, r);
    return s;
  endfunction

  function automatic st_t rand_st();
    st_t s;
    for (int i = 0; i < 5; i++) s[i] = {$urandom, $urandom};
    return s;
  endfunction

  always_comb rs_in = full ? round_f(rs_out, int'(rnd)) : pc(rs_out, int'(rnd));

  task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  // monitor: round index per RUN cycle, then latency/result/busy length on done
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rstn) run_cnt = 0;
    else begin
      if (busy && sb.size() > 0) begin
        chk("round_o", 320'(rnd), 320'(12 - sb[0].n + run_cnt));
        run_cnt++;
      end
      if (done) begin
        if (sb.size() == 0) chk("unexpected_done", 320'(done), 320'(0));
        else begin
          e = sb.pop_front();
          chk("done_cycle", 320'(cyc), 320'(e.acc + e.n));
          chk("state_o", st_out, e.st);
          chk("busy_cycles", 320'(run_cnt), 320'(e.n));
          run_cnt = 0;
        end
      end
    end
  end

  task automatic issue(input logic m, input st_t s, input logic f);
    int g = 0;
    while ((busy || done) && g < 100) begin @(negedge clk); g++; end
    if (g >= 100) chk("idle_timeout", 320'(g), 320'(0));
    full = f; mode = m; st_in = s; start = 1;
    sb.push_back('{perm(s, m ? 6 : 12, f), cyc + 1, m ? 6 : 12});
    @(negedge clk);
    start = 0; mode = 1'($urandom); st_in = rand_st();
  endtask

  task automatic drain();
    for (int g = 0; g < 200 && sb.size() > 0; g++) @(negedge clk);
    if (sb.size() > 0) begin
      chk("drain_timeout", 320'(sb.size()), 320'(0));
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    st_t s;
    int a1, a2;
    #2 rstn = 0;
    repeat (2) @(negedge clk);
    chk("rst_state_o", st_out, '0);
    chk("rst_round_o", 320'(rnd), '0);
    chk("rst_busy", 320'(busy), '0);
    chk("rst_done", 320'(done), '0);
    rstn = 1;
    @(negedge clk);
    s = '0; s[2] = 64'hFF;
    issue(0, s, 0); drain();
    chk("p12_pc_x2", 320'(st_out[2]), 320'(64'hFF));
    issue(1, s, 0); drain();
    chk("p6_pc_x2_lsb", 320'(st_out[2][7:0]), 320'(8'hEE));
    s[0] = 64'h80400C0600000000;
    s[1] = 64'h0001020304050607; s[2] = 64'h08090A0B0C0D0E0F;
    s[3] = 64'h0001020304050607; s[4] = 64'h08090A0B0C0D0E0F;
    issue(0, s, 1); drain();
    for (int i = 0; i < 20; i++) begin
      issue(1'($urandom), rand_st(), 1'($urandom));
      if ($urandom_range(0, 1) == 1) drain();
    end
    drain();
    s = rand_st();
    full = 1; mode = 1; st_in = s; start = 1;
    a1 = cyc + 1;
`ifdef PERM_BACK_TO_BACK_EN
    a2 = a1 + 6 + 1;
`else
    a2 = a1 + 6 + 2;
`endif
    sb.push_back('{perm(s, 6, 1), a1, 6});
    sb.push_back('{perm(s, 6, 1), a2, 6});
    while (cyc < a2) @(negedge clk);
    start = 0;
    drain();
    issue(0, rand_st(), 1);
    repeat (4) @(negedge clk);
    #2 rstn = 0;
    #1;
    chk("abort_state_o", st_out, '0);
    chk("abort_round_o", 320'(rnd), '0);
    chk("abort_busy", 320'(busy), '0);
    chk("abort_done", 320'(done), '0);
    sb.delete();
    @(negedge clk);
    rstn = 1;
    repeat (20) @(negedge clk);
    chk("idle_after_abort", 320'(busy), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
